// File: rtl/router_fifo.sv
// Per-port output FIFO of the 1x3 router: stores header-tagged bytes and
// tracks packet boundaries on the read side so rd_busy spans a whole packet.
module router_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             rd_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [6:0]       pkt_cnt_q, pkt_cnt_d;
    logic [WIDTH:0]   mem_q [DEPTH];

    logic             flush;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH:0]   rd_word;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign flush   = rst | soft_reset;
    assign wr_acc  = write_enb && !full;
    assign rd_acc  = read_enb && !empty;
    assign rd_word = mem_q[rd_ptr_q[AW-1:0]];

    assign data_out = data_out_q;
    assign rd_busy  = (pkt_cnt_q != 7'd0);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        pkt_cnt_d  = pkt_cnt_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            data_out_d = '0;
            pkt_cnt_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                data_out_d = rd_word[WIDTH-1:0];
                // Header carries payload length in [7:2]; count includes the parity byte.
                if (rd_word[WIDTH]) begin
                    pkt_cnt_d = {1'b0, rd_word[7:2]} + 7'd1;
                end else if (pkt_cnt_q != 7'd0) begin
                    pkt_cnt_d = pkt_cnt_q - 7'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && wr_acc) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            data_out_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            data_out_q <= data_out_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed packet scenarios plus a
// randomized phase, all compared against a queue-based behavioural model.
module tb_router_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             soft_reset = 1'b0;
    logic             write_enb = 1'b0;
    logic             lfd_state = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             read_enb = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             rd_busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model: a plain queue of tagged bytes, last read byte, packet countdown.
    logic [8:0] model_q [$];
    logic [7:0] m_dout = 8'h00;
    int         m_cnt  = 0;

    router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .rd_busy    (rd_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic rd_ok;
        logic wr_ok;
        logic [8:0] w;
        if (rst || soft_reset) begin
            model_q.delete();
            m_dout = 8'h00;
            m_cnt  = 0;
        end else begin
            rd_ok = read_enb && (model_q.size() > 0);
            wr_ok = write_enb && (model_q.size() < DEPTH);
            if (rd_ok) begin
                w = model_q.pop_front();
                m_dout = w[7:0];
                if (w[8]) m_cnt = int'(w[7:2]) + 1;
                else if (m_cnt > 0) m_cnt = m_cnt - 1;
            end
            if (wr_ok) model_q.push_back({lfd_state, data_in});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("model.data_out", data_out, m_dout);
            checkOutput("model.full", {7'd0, full}, {7'd0, model_q.size() == DEPTH});
            checkOutput("model.empty", {7'd0, empty}, {7'd0, model_q.size() == 0});
            checkOutput("model.rd_busy", {7'd0, rd_busy}, {7'd0, m_cnt != 0});
        end
    end

    task automatic applyStimulus(input logic we, input logic lfd, input logic [7:0] din,
                                 input logic re, input logic sr, input logic rs);
        write_enb  = we;
        lfd_state  = lfd;
        data_in    = din;
        read_enb   = re;
        soft_reset = sr;
        rst        = rs;
        @(posedge clk);
        @(negedge clk);
        write_enb  = 1'b0;
        lfd_state  = 1'b0;
        read_enb   = 1'b0;
        soft_reset = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic wr(input logic lfd, input logic [7:0] din);
        applyStimulus(1'b1, lfd, din, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd(input string name, input logic [7:0] exp_data, input logic exp_busy);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput({name, ".data"}, data_out, exp_data);
        checkOutput({name, ".busy"}, {7'd0, rd_busy}, {7'd0, exp_busy});
    endtask

    initial begin
        logic [7:0] pkt [5];
        pkt = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h2C};

        // Reset held two cycles
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        checkOutput("reset.empty", {7'd0, empty}, 8'h01);
        checkOutput("reset.full", {7'd0, full}, 8'h00);
        checkOutput("reset.data_out", data_out, 8'h00);
        checkOutput("reset.rd_busy", {7'd0, rd_busy}, 8'h00);
        rd("empty_read", 8'h00, 1'b0);

        // Packet pass-through
        for (int i = 0; i < 5; i++) wr(i == 0, pkt[i]);
        for (int i = 0; i < 5; i++) rd($sformatf("pkt[%0d]", i), pkt[i], i < 4);
        checkOutput("pkt.empty", {7'd0, empty}, 8'h01);

        // Full boundary with dropped 17th write
        for (int i = 0; i < 16; i++) wr(1'b0, 8'(i));
        checkOutput("full.after16", {7'd0, full}, 8'h01);
        wr(1'b0, 8'hFF);
        checkOutput("full.after17", {7'd0, full}, 8'h01);

        // Simultaneous read/write at full: write rejected
        applyStimulus(1'b1, 1'b0, 8'hAA, 1'b1, 1'b0, 1'b0);
        checkOutput("simfull.full", {7'd0, full}, 8'h00);
        checkOutput("simfull.data", data_out, 8'h00);
        for (int i = 1; i < 16; i++) rd($sformatf("drain[%0d]", i), 8'(i), 1'b0);
        checkOutput("drain.empty", {7'd0, empty}, 8'h01);

        // Simultaneous access at 8 entries across pointer wrap
        for (int i = 0; i < 8; i++) wr(1'b0, 8'h40 + 8'(i));
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0, 8'h80 + 8'(i), 1'b1, 1'b0, 1'b0);
        checkOutput("sim8.data", data_out, 8'h80 + 8'd31);
        for (int i = 0; i < 8; i++) rd($sformatf("sim8_drain[%0d]", i), 8'h80 + 8'(32 + i), 1'b0);
        checkOutput("sim8.empty", {7'd0, empty}, 8'h01);

        // Soft reset mid-packet
        wr(1'b1, 8'h28);
        for (int i = 0; i < 11; i++) wr(1'b0, 8'h90 + 8'(i));
        rd("sr.hdr", 8'h28, 1'b1);
        rd("sr.b1", 8'h90, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("sr.empty", {7'd0, empty}, 8'h01);
        checkOutput("sr.rd_busy", {7'd0, rd_busy}, 8'h00);
        checkOutput("sr.data_out", data_out, 8'h00);
        wr(1'b1, 8'h04);
        wr(1'b0, 8'h77);
        wr(1'b0, 8'h73);
        rd("fresh.hdr", 8'h04, 1'b1);
        rd("fresh.pay", 8'h77, 1'b1);
        rd("fresh.par", 8'h73, 1'b0);

        // Stray untagged byte
        wr(1'b0, 8'h55);
        rd("stray", 8'h55, 1'b0);

        // Randomized traffic with fill/drain biased phases
        for (int i = 0; i < 2000; i++) begin
            bit fill_phase;
            fill_phase = ((i / 150) % 2) == 0;
            applyStimulus($urandom_range(0, 3) < (fill_phase ? 3 : 1),
                          $urandom_range(0, 5) == 0,
                          8'($urandom),
                          $urandom_range(0, 3) < (fill_phase ? 1 : 3),
                          $urandom_range(0, 199) == 0,
                          $urandom_range(0, 499) == 0);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
